store_trace_checker: RTL
========================

Name: store_trace_checker

Overview:
- Synthesizable, parametrised self-checking monitor for processor data-memory store traffic; replaces per-program ad-hoc testbench checks.
- Sits beside a core (SingleCycle or successors), sniffing memwrite/dataadr/writedata.
- Compares stores against a programmable ordered list of expected (address, data) pairs; reports pass, fail or timeout with diagnostics.
- Supports a strict mode (any unexpected store fails) and a filtered mode (non-matching addresses ignored).

Parameters:
DATA_W, 32, width of store data and expected data
ADDR_W, 32, width of store address and expected address
DEPTH, 8, maximum number of expected entries (power of two, >=2)
TIMEOUT, 1000, cycles after start with no final match before timeout; 0 disables timeout
STRICT, 0, 1 = any store not matching the current expected entry fails; 0 = stores to other addresses ignored

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
exp_we  in  1  write one expected entry (only accepted in IDLE)
exp_idx  in  $clog2(DEPTH)  entry index for exp_we
exp_addr  in  ADDR_W  expected store address
exp_data  in  DATA_W  expected store data
num_exp  in  $clog2(DEPTH)+1  number of valid entries, sampled on start; 1..DEPTH
start  in  1  one-cycle pulse: IDLE -> RUN
memwrite  in  1  core store strobe
dataadr  in  ADDR_W  core store address
writedata  in  DATA_W  core store data
busy  out  1  high in RUN
done  out  1  high in PASS/FAIL/TIMEOUT
pass  out  1  high only in PASS
fail  out  1  high in FAIL or TIMEOUT
timed_out  out  1  high only in TIMEOUT
match_cnt  out  $clog2(DEPTH)+1  entries matched so far
fail_addr  out  ADDR_W  dataadr of offending store (0 on timeout)
fail_data  out  DATA_W  writedata of offending store (0 on timeout)
cycle_cnt  out  32  cycles spent in RUN, saturating at all-ones

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; match_cnt=0; cycle_cnt=0. Expected table contents undefined (not cleared). Reset asserted mid-RUN aborts immediately.
- All other logic on rising clk. Store inputs sampled when memwrite=1 at the edge.
- IDLE: exp_we writes table[exp_idx]. exp_we outside IDLE is ignored.
- IDLE, start=1: latch num_exp (0 or >DEPTH treated as DEPTH); clear match_cnt, cycle_cnt, fail_addr, fail_data; enter RUN next cycle. Stores in the start cycle are not checked.
- RUN, each cycle: cycle_cnt += 1 (saturating). Let e = table[match_cnt].
  - memwrite=1 and dataadr==e.addr and writedata==e.data: match_cnt += 1. If the new count equals num_exp, enter PASS.
  - memwrite=1 and dataadr==e.addr and data mismatch: enter FAIL; capture fail_addr/fail_data. This applies in both modes.
  - memwrite=1 and dataadr!=e.addr: STRICT=1 -> FAIL with capture; STRICT=0 -> ignored.
  - TIMEOUT!=0 and cycle_cnt reaches TIMEOUT-1 with no pass this cycle: enter TIMEOUT. A match completing the list in the same cycle wins (PASS).
- PASS/FAIL/TIMEOUT are sticky. start re-enters RUN and clears diagnostics; the table is retained. Stores after done are ignored.
- Outputs are registered and decoded from state; done/pass/fail assert in the cycle after the deciding edge.
- One check per cycle: back-to-back stores each compare against successive entries.

Test Plan:
- STRICT=0, table {(20,0)}, num_exp=1; core runs the beq program (stores 20<-0) -> pass=1, match_cnt=1, fail=0, one cycle after the store.
- STRICT=0, table {(20,0)}; store (20,50) (beq not taken) -> fail=1, fail_addr=20, fail_data=50, pass=0.
- STRICT=1, table {(84,7),(80,7)}; stores (80,7) then (84,7) -> fail on first store, fail_addr=80, match_cnt=0. Same with STRICT=0 -> ignores first store, then fails on (84,7)? No: entry 0 is (84,7), so (84,7) matches; after that entry 1 (80,7) is never stored -> TIMEOUT.
- TIMEOUT=10, no stores after start -> timed_out=1, fail=1, fail_addr=0, cycle_cnt=9; TIMEOUT=0 -> busy remains high indefinitely.
- DEPTH=8, eight back-to-back matching stores on consecutive cycles -> pass one cycle after the 8th store, match_cnt=8. Then start again with the same stores -> pass again; the table is retained.
- Reset pulled low mid-RUN after 2 matches -> all outputs 0 immediately (asynchronous), state IDLE; exp_we is accepted on the next edge.

Source files
------------

// File: rtl/store_trace_checker_if.sv
// Bundle of the expected-table load port, the sniffed core store bus and
// the checker status outputs. The bench/core side uses the master modport,
// the checker uses the slave modport.
//
// Handshake: there is no valid/ready pair here. exp_we and start are
// single-cycle strobes sampled on the rising clock; memwrite is a
// qualifier, so dataadr/writedata are only looked at on edges where
// memwrite=1. Nothing is ever back-pressured.
interface store_trace_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  // expected-table programming and run control
  logic              exp_we;
  logic [IW-1:0]     exp_idx;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic [CW-1:0]     num_exp;
  logic              start;

  // sniffed core store bus
  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;

  // status and diagnostics
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic              timed_out;
  logic [CW-1:0]     match_cnt;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic [31:0]       cycle_cnt;
  logic [2:0]        dbg_state;

  modport master (
    output exp_we, exp_idx, exp_addr, exp_data, num_exp, start,
    output memwrite, dataadr, writedata,
    input  busy, done, pass, fail, timed_out, match_cnt,
    input  fail_addr, fail_data, cycle_cnt, dbg_state
  );

  modport slave (
    input  exp_we, exp_idx, exp_addr, exp_data, num_exp, start,
    input  memwrite, dataadr, writedata,
    output busy, done, pass, fail, timed_out, match_cnt,
    output fail_addr, fail_data, cycle_cnt, dbg_state
  );
endinterface

// File: rtl/store_trace_checker.sv
// Store trace checker: watches the core's data-memory store strobe and
// compares each store against an ordered table of expected (addr, data)
// pairs. Ends sticky in PASS, FAIL or TIMEOUT; dbg_state exposes the FSM.
module store_trace_checker #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1000,
  parameter int STRICT  = 0
) (
  input logic                  clk,
  input logic                  reset,
  store_trace_checker_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_PASS = 3'd2;
  localparam logic [2:0] S_FAIL = 3'd3;
  localparam logic [2:0] S_TOUT = 3'd4;

  localparam bit          STRICT_EN = (STRICT != 0);
  localparam bit          TO_EN     = (TIMEOUT != 0);
  // cycle_cnt value whose arrival ends the run (unused when TO_EN=0)
  localparam logic [31:0] TO_LAST   = TO_EN ? 32'(TIMEOUT - 1) : 32'd0;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     num_q, num_d;
  logic [CW-1:0]     match_q, match_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;

  // expected table: deliberately not reset, only rewritten from IDLE
  logic [ADDR_W-1:0] tab_addr_q [DEPTH];
  logic [DATA_W-1:0] tab_data_q [DEPTH];

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic [CW-1:0]     match_inc;
  logic [31:0]       cyc_inc;
  logic              addr_hit;
  logic              data_hit;

  // current entry is the one after the last match; match_q < num_q <= DEPTH
  // whenever it is used, so the low bits index the table directly
  assign cur_addr  = tab_addr_q[match_q[IW-1:0]];
  assign cur_data  = tab_data_q[match_q[IW-1:0]];
  assign addr_hit  = bus.memwrite && (bus.dataadr == cur_addr);
  assign data_hit  = (bus.writedata == cur_data);
  assign match_inc = match_q + 1'b1;
  assign cyc_inc   = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;

  // table writes are only honoured while the checker is idle
  always_ff @(posedge clk) begin
    if (bus.exp_we && (state_q == S_IDLE)) begin
      tab_addr_q[bus.exp_idx] <= bus.exp_addr;
      tab_data_q[bus.exp_idx] <= bus.exp_data;
    end
  end

  // next-state: start handling, per-cycle store compare, timeout
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    match_d = match_q;
    cyc_d   = cyc_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL, S_TOUT: begin
        if (bus.start) begin
          // 0 or an out-of-range count means "use the whole table"
          if ((bus.num_exp == '0) || (bus.num_exp > DEPTH_C)) num_d = DEPTH_C;
          else num_d = bus.num_exp;
          match_d = '0;
          cyc_d   = '0;
          faddr_d = '0;
          fdata_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        if (addr_hit && data_hit) begin
          match_d = match_inc;
          if (match_inc == num_q) state_d = S_PASS;
        end else if (bus.memwrite && (addr_hit || STRICT_EN)) begin
          faddr_d = bus.dataadr;
          fdata_d = bus.writedata;
          state_d = S_FAIL;
        end
        // a store that completes the list on the last allowed cycle wins
        if ((state_d == S_RUN) && TO_EN && (cyc_inc >= TO_LAST)) state_d = S_TOUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and diagnostics registers; reset aborts any run immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      match_q <= '0;
      cyc_q   <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      match_q <= match_d;
      cyc_q   <= cyc_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.pass      = (state_q == S_PASS);
  assign bus.timed_out = (state_q == S_TOUT);
  assign bus.fail      = (state_q == S_FAIL) || (state_q == S_TOUT);
  assign bus.done      = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TOUT);
  assign bus.match_cnt = match_q;
  assign bus.fail_addr = faddr_q;
  assign bus.fail_data = fdata_q;
  assign bus.cycle_cnt = cyc_q;
  assign bus.dbg_state = state_q;
endmodule
